// File: rtl/riscv_noc_router_output_arbiter.sv
// Wormhole output-port arbiter: round-robin packet grant, then the whole packet is locked to one input.
// Optional macro RISCV_NOC_ROUTER_OUTPUT_REG_EN inserts a 2-entry output FIFO; default is a combinational output mux.
module riscv_noc_router_output_arbiter #(
    parameter int PLEN   = 64,
    parameter int INPUTS = 7
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [INPUTS*PLEN-1:0]   in_flit,
    input  logic [INPUTS-1:0]        in_last,
    input  logic [INPUTS-1:0]        in_valid,
    output logic [INPUTS-1:0]        in_ready,
    output logic [PLEN-1:0]          out_flit,
    output logic                     out_last,
    output logic                     out_valid,
    input  logic                     out_ready
);

    localparam int          IW = (INPUTS > 1) ? $clog2(INPUTS) : 1;
    localparam int unsigned N  = INPUTS;

    typedef enum logic {IDLE, WORM} state_e;

    state_e        state_q;
    logic [IW-1:0] worm_q;
    logic [IW-1:0] last_q;

    logic [IW-1:0] winner;
    logic          any_valid;
    logic [IW-1:0] sel;
    logic          sel_valid;
    logic [PLEN-1:0] sel_flit;
    logic          sel_last;
    logic          accept;
    logic          xfer;

    // Round-robin scan starting just after the previous winner.
    always_comb begin
        winner    = '0;
        any_valid = 1'b0;
        for (int unsigned k = 1; k <= N; k++) begin
            int unsigned cand;
            cand = (32'(last_q) + k) % N;
            if (!any_valid && in_valid[cand]) begin
                any_valid = 1'b1;
                winner    = IW'(cand);
            end
        end
    end

    always_comb begin
        sel       = (state_q == WORM) ? worm_q : winner;
        sel_valid = (state_q == WORM) ? in_valid[sel] : any_valid;
        sel_flit  = in_flit[sel*PLEN +: PLEN];
        sel_last  = in_last[sel];
    end

    always_comb begin
        in_ready = '0;
        if (!rst && sel_valid) begin
            in_ready[sel] = accept;
        end
        xfer = !rst && sel_valid && accept;
    end

    // A tail in WORM only returns to IDLE; the next winner is picked a cycle later.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            worm_q  <= '0;
            last_q  <= IW'(N - 1);
        end else begin
            case (state_q)
                IDLE: begin
                    if (xfer) begin
                        last_q <= winner;
                        if (!sel_last) begin
                            state_q <= WORM;
                            worm_q  <= winner;
                        end
                    end
                end
                WORM: begin
                    if (xfer && sel_last) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef RISCV_NOC_ROUTER_OUTPUT_REG_EN
    logic [PLEN-1:0] fifo_flit_q [2];
    logic [1:0]      fifo_last_q;
    logic            wr_q;
    logic            rd_q;
    logic [1:0]      count_q;
    logic            pop;

    // Accept depends only on the registered count, so out_ready never reaches in_ready.
    always_comb begin
        accept    = (count_q != 2'd2);
        out_valid = (count_q != 2'd0);
        pop       = out_valid && out_ready;
        out_flit  = out_valid ? fifo_flit_q[rd_q] : '0;
        out_last  = out_valid && fifo_last_q[rd_q];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fifo_flit_q[0] <= '0;
            fifo_flit_q[1] <= '0;
            fifo_last_q    <= '0;
            wr_q           <= 1'b0;
            rd_q           <= 1'b0;
            count_q        <= '0;
        end else begin
            if (xfer) begin
                fifo_flit_q[wr_q] <= sel_flit;
                fifo_last_q[wr_q] <= sel_last;
                wr_q              <= ~wr_q;
            end
            if (pop) begin
                rd_q <= ~rd_q;
            end
            case ({xfer, pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end
`else
    always_comb begin
        accept    = out_ready;
        out_valid = !rst && sel_valid;
        out_flit  = out_valid ? sel_flit : '0;
        out_last  = out_valid && sel_last;
    end
`endif

endmodule

// File: tb/tb_riscv_noc_router_output_arbiter.sv
// Directed self-checking bench for riscv_noc_router_output_arbiter (default 7 inputs, 64-bit flits).
module tb_riscv_noc_router_output_arbiter;

    localparam int PLEN   = 64;
    localparam int INPUTS = 7;

    logic                   clk;
    logic                   rst;
    logic [INPUTS*PLEN-1:0] in_flit;
    logic [INPUTS-1:0]      in_last;
    logic [INPUTS-1:0]      in_valid;
    logic [INPUTS-1:0]      in_ready;
    logic [PLEN-1:0]        out_flit;
    logic                   out_last;
    logic                   out_valid;
    logic                   out_ready;

    int checks = 0;
    int errors = 0;

    riscv_noc_router_output_arbiter #(
        .PLEN   (PLEN),
        .INPUTS (INPUTS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_flit   (in_flit),
        .in_last   (in_last),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_flit  (out_flit),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic set_flit(input int i, input logic [PLEN-1:0] v, input logic l);
        in_flit[i*PLEN +: PLEN] = v;
        in_last[i]              = l;
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        in_valid = '1;
        for (int i = 0; i < INPUTS; i++) set_flit(i, 64'hF00 + 64'(i), 1'b0);
        advance();
        #2;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
        checks++; if (out_flit !== '0) begin errors++; $display("FAIL rst_out_flit got=%h exp=0", out_flit); end
        checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL rst_out_last got=%b exp=0", out_last); end
        checks++; if (in_ready !== '0) begin errors++; $display("FAIL rst_in_ready got=%b exp=0", in_ready); end
        advance();
        rst      = 1'b0;
        in_valid = '0;
        #2;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL post_rst_out_valid got=%b exp=0", out_valid); end
        advance();
    endtask

    // Inputs 0 and 2 with single-flit packets alternate, 0 first.
    task automatic test_alternate();
        in_valid = 7'b0000101;
        set_flit(0, 64'h100, 1'b1);
        set_flit(2, 64'h102, 1'b1);
        for (int c = 0; c < 4; c++) begin
            int g;
            g = (c % 2 == 0) ? 0 : 2;
            #2;
            checks++; if (in_ready !== 7'(1 << g)) begin errors++; $display("FAIL alt_grant c=%0d got=%b exp=%b", c, in_ready, 7'(1 << g)); end
            checks++; if (out_flit !== 64'h100 + 64'(g)) begin errors++; $display("FAIL alt_flit c=%0d got=%h exp=%h", c, out_flit, 64'h100 + 64'(g)); end
            checks++; if (out_last !== 1'b1) begin errors++; $display("FAIL alt_last c=%0d got=%b exp=1", c, out_last); end
            advance();
        end
        in_valid = '0;
    endtask

    // Input 3 holds the output for a 4-flit packet while input 1 waits.
    task automatic test_worm();
        in_valid = 7'b0001010;
        set_flit(1, 64'h111, 1'b1);
        for (int f = 0; f < 4; f++) begin
            set_flit(3, 64'h300 + 64'(f), f == 3);
            #2;
            checks++; if (in_ready !== 7'b0001000) begin errors++; $display("FAIL worm_grant f=%0d got=%b exp=0001000", f, in_ready); end
            checks++; if (out_flit !== 64'h300 + 64'(f)) begin errors++; $display("FAIL worm_flit f=%0d got=%h exp=%h", f, out_flit, 64'h300 + 64'(f)); end
            checks++; if (out_last !== (f == 3)) begin errors++; $display("FAIL worm_last f=%0d got=%b exp=%b", f, out_last, f == 3); end
            advance();
        end
        in_valid = 7'b0000010;
        #2;
        checks++; if (in_ready !== 7'b0000010) begin errors++; $display("FAIL worm_next_grant got=%b exp=0000010", in_ready); end
        checks++; if (out_flit !== 64'h111) begin errors++; $display("FAIL worm_next_flit got=%h exp=111", out_flit); end
        advance();
        in_valid = '0;
    endtask

    // Worm input 5 idles for 3 cycles; input 0 must not steal the output.
    task automatic test_idle_worm();
        in_valid = 7'b0100001;
        set_flit(0, 64'h0A0, 1'b1);
        set_flit(5, 64'h500, 1'b0);
        #2;
        checks++; if (in_ready !== 7'b0100000) begin errors++; $display("FAIL idle_hdr_grant got=%b exp=0100000", in_ready); end
        checks++; if (out_flit !== 64'h500) begin errors++; $display("FAIL idle_hdr_flit got=%h exp=500", out_flit); end
        advance();
        in_valid = 7'b0000001;
        for (int c = 0; c < 3; c++) begin
            #2;
            checks++; if ((in_ready & 7'b1011111) !== '0) begin errors++; $display("FAIL idle_hold c=%0d got=%b exp=0", c, in_ready); end
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL idle_out_valid c=%0d got=%b exp=0", c, out_valid); end
            advance();
        end
        in_valid = 7'b0100001;
        set_flit(5, 64'h501, 1'b1);
        #2;
        checks++; if (in_ready !== 7'b0100000) begin errors++; $display("FAIL idle_tail_grant got=%b exp=0100000", in_ready); end
        checks++; if (out_flit !== 64'h501 || out_last !== 1'b1) begin errors++; $display("FAIL idle_tail got=%h/%b exp=501/1", out_flit, out_last); end
        advance();
        in_valid = 7'b0000001;
        #2;
        checks++; if (in_ready !== 7'b0000001) begin errors++; $display("FAIL idle_next_grant got=%b exp=0000001", in_ready); end
        advance();
        in_valid = '0;
    endtask

`ifdef RISCV_NOC_ROUTER_OUTPUT_REG_EN
    task automatic test_backpressure();
        out_ready = 1'b0;
        in_valid  = 7'b0010000;
        set_flit(4, 64'hA1, 1'b1);
        #2;
        checks++; if (in_ready !== 7'b0010000) begin errors++; $display("FAIL bp_push1 got=%b exp=0010000", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_latency got=%b exp=0", out_valid); end
        advance();
        set_flit(4, 64'hA2, 1'b1);
        #2;
        checks++; if (in_ready !== 7'b0010000) begin errors++; $display("FAIL bp_push2 got=%b exp=0010000", in_ready); end
        advance();
        set_flit(4, 64'hA3, 1'b1);
        for (int c = 0; c < 3; c++) begin
            #2;
            checks++; if (in_ready !== '0) begin errors++; $display("FAIL bp_full c=%0d got=%b exp=0", c, in_ready); end
            checks++; if (out_flit !== 64'hA1) begin errors++; $display("FAIL bp_head c=%0d got=%h exp=a1", c, out_flit); end
            advance();
        end
        in_valid  = '0;
        out_ready = 1'b1;
        #2;
        checks++; if (out_valid !== 1'b1 || out_flit !== 64'hA1) begin errors++; $display("FAIL bp_out1 got=%b/%h exp=1/a1", out_valid, out_flit); end
        advance();
        #2;
        checks++; if (out_valid !== 1'b1 || out_flit !== 64'hA2) begin errors++; $display("FAIL bp_out2 got=%b/%h exp=1/a2", out_valid, out_flit); end
        advance();
        #2;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_empty got=%b exp=0", out_valid); end
        advance();
    endtask
`else
    task automatic test_backpressure();
        out_ready = 1'b0;
        in_valid  = 7'b0010000;
        set_flit(4, 64'hA1, 1'b1);
        for (int c = 0; c < 2; c++) begin
            #2;
            checks++; if (in_ready !== '0) begin errors++; $display("FAIL bp_stall c=%0d got=%b exp=0", c, in_ready); end
            checks++; if (out_valid !== 1'b1 || out_flit !== 64'hA1) begin errors++; $display("FAIL bp_present c=%0d got=%b/%h exp=1/a1", c, out_valid, out_flit); end
            advance();
        end
        out_ready = 1'b1;
        #2;
        checks++; if (in_ready !== 7'b0010000) begin errors++; $display("FAIL bp_release got=%b exp=0010000", in_ready); end
        advance();
        in_valid = '0;
    endtask
`endif

    // Reset on the 2nd flit of a 3-flit worm from input 2 aborts it.
    task automatic test_reset_mid_worm();
        in_valid = 7'b0000100;
        set_flit(2, 64'h200, 1'b0);
        #2;
        checks++; if (in_ready !== 7'b0000100) begin errors++; $display("FAIL rmw_hdr got=%b exp=0000100", in_ready); end
        advance();
        set_flit(2, 64'h201, 1'b0);
        rst = 1'b1;
`ifndef RISCV_NOC_ROUTER_OUTPUT_REG_EN
        #2;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmw_during_rst got=%b exp=0", out_valid); end
`endif
        advance();
        rst      = 1'b0;
        in_valid = '0;
        #2;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmw_after_rst got=%b exp=0", out_valid); end
        advance();
        in_valid = 7'b0000101;
        set_flit(0, 64'h0B0, 1'b1);
        #2;
        checks++; if (in_ready !== 7'b0000001) begin errors++; $display("FAIL rmw_rearb got=%b exp=0000001", in_ready); end
        advance();
        in_valid = '0;
    endtask

    // All inputs valid with 1-flit packets: grants rotate 0..6.
    task automatic test_round_robin();
        int grants [INPUTS];
        for (int i = 0; i < INPUTS; i++) grants[i] = 0;
        rst = 1'b1;
        advance();
        rst = 1'b0;
        for (int i = 0; i < INPUTS; i++) set_flit(i, 64'h600 + 64'(i), 1'b1);
        in_valid = '1;
        for (int c = 0; c < INPUTS; c++) begin
            #2;
            checks++; if (in_ready !== 7'(1 << c)) begin errors++; $display("FAIL rr_grant c=%0d got=%b exp=%b", c, in_ready, 7'(1 << c)); end
            for (int i = 0; i < INPUTS; i++) if (in_ready[i]) grants[i]++;
            advance();
        end
        in_valid = '0;
        for (int i = 0; i < INPUTS; i++) begin
            checks++; if (grants[i] !== 1) begin errors++; $display("FAIL rr_count i=%0d got=%0d exp=1", i, grants[i]); end
        end
    endtask

    initial begin
        rst       = 1'b1;
        in_flit   = '0;
        in_last   = '0;
        in_valid  = '0;
        out_ready = 1'b1;
        advance();
        test_reset();
        test_alternate();
        test_worm();
        test_idle_worm();
        test_backpressure();
        test_reset_mid_worm();
        test_round_robin();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
